// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: serial line in,
// byte/flag handshake out. The consumer side is the master.
interface uart_rx_if;
    logic       RXD;
    logic       ACK;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FERR;
    logic       OVR;

    modport master (
        output RXD,
        output ACK,
        input  DATA,
        input  VALID,
        input  BUSY,
        input  FERR,
        input  OVR
    );

    modport slave (
        input  RXD,
        input  ACK,
        output DATA,
        output VALID,
        output BUSY,
        output FERR,
        output OVR
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a single start-edge alignment,
// sticky framing/overrun flags, and a break state for held-low lines.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_MID  = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic          sync0;
    logic          sync1;
    logic          rxs;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [2:0]    bidx;
    logic [2:0]    bidx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;

    logic [7:0]    data_q;
    logic [7:0]    data_n;
    logic          valid_q;
    logic          valid_n;
    logic          ferr_q;
    logic          ferr_n;
    logic          ovr_q;
    logic          ovr_n;

    logic          load;
    logic          ferr_set;

    assign rxs = sync1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            state   <= IDLE;
            timer   <= '0;
            bidx    <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync0   <= bus.RXD;
            sync1   <= sync0;
            state   <= state_n;
            timer   <= timer_n;
            bidx    <= bidx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bidx_n   = bidx;
        shreg_n  = shreg;
        load     = 1'b0;
        ferr_set = 1'b0;

        unique case (state)
            IDLE: begin
                timer_n = '0;
                bidx_n  = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (timer == T_MID) begin
                    timer_n = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    bidx_n  = bidx + 3'd1;
                    if (bidx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == T_LAST) begin
                    timer_n = '0;
                    if (rxs) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            BREAK: begin
                // hold here so a stuck-low line is not decoded as 0x00s
                timer_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                bidx_n  = '0;
            end
        endcase
    end

    always_comb begin
        data_n  = data_q;
        valid_n = valid_q;
        ferr_n  = ferr_q;
        ovr_n   = ovr_q;

        // a fresh byte outranks a same-cycle acknowledge
        if (load) begin
            data_n  = shreg;
            valid_n = 1'b1;
        end else if (bus.ACK) begin
            valid_n = 1'b0;
        end

        if (load && valid_q && !bus.ACK) begin
            ovr_n = 1'b1;
        end else if (bus.ACK) begin
            ovr_n = 1'b0;
        end

        if (ferr_set) begin
            ferr_n = 1'b1;
        end else if (bus.ACK) begin
            ferr_n = 1'b0;
        end
    end

    assign bus.DATA  = data_q;
    assign bus.VALID = valid_q;
    assign bus.BUSY  = (state != IDLE);
    assign bus.FERR  = ferr_q;
    assign bus.OVR   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: frame-level model plus a
// scoreboard monitor that pops expected bytes as the receiver loads them.
module tb_uart_rx;
    logic CLK;
    logic RST;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;

    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // a load is visible as VALID rising or DATA changing under VALID
    always @(negedge CLK) begin
        if (bus.VALID === 1'b1 && (!pv || bus.DATA !== pd)) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_byte: got %0h want none", bus.DATA);
            end else begin
                chk("scoreboard_byte", bus.DATA, exp_q.pop_front());
            end
        end
        pv = bus.VALID;
        pd = bus.DATA;
    end

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_all(input string nm, input bit busy);
        chk({nm, ".data"}, bus.DATA, m_data);
        chk({nm, ".valid"}, bus.VALID, m_valid);
        chk({nm, ".ferr"}, bus.FERR, m_ferr);
        chk({nm, ".ovr"}, bus.OVR, m_ovr);
        chk({nm, ".busy"}, bus.BUSY, busy);
    endtask

    // Drive one 160-clock frame; ACK pulses on clock ack_n and RST is
    // held over clocks [rst_lo, rst_hi). Stops early after len clocks.
    task automatic frame(input logic [7:0] b, input bit stop,
                         input int ack_n, input int rst_lo,
                         input int rst_hi, input int len);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int n = 0; n < len; n++) begin
            bus.RXD = bits[n/16];
            bus.ACK = (n == ack_n);
            RST     = (n >= rst_lo && n < rst_hi);
            @(negedge CLK);
        end
        bus.ACK = 1'b0;
        RST     = 1'b0;
    endtask

    // Clock 154 is the cycle whose closing edge samples the stop bit.
    task automatic good(input logic [7:0] b, input bit ack_load);
        exp_q.push_back(b);
        frame(b, 1'b1, ack_load ? 154 : -1, -1, -1, 160);
        if (ack_load) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else if (m_valid) begin
            m_ovr = 1'b1;
        end
        m_valid = 1'b1;
        m_data  = b;
    endtask

    task automatic bad(input logic [7:0] b, input bit ack_load);
        frame(b, 1'b0, ack_load ? 154 : -1, -1, -1, 160);
        if (ack_load) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        m_ferr = 1'b1;
    endtask

    task automatic ack_pulse();
        bus.ACK = 1'b1;
        @(negedge CLK);
        bus.ACK = 1'b0;
        @(negedge CLK);
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [7:0] pick_new(input logic [7:0] avoid);
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == avoid) v = v ^ 8'h5A;
        return v;
    endfunction

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        RST     = 1'b1;
        bus.RXD = 1'b1;
        bus.ACK = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_all("reset", 1'b0);

        good(8'hA5, 1'b0);
        check_all("single", 1'b0);
        ack_pulse();
        check_all("single_ack", 1'b0);

        bus.RXD = 1'b0;
        repeat (4) @(negedge CLK);
        bus.RXD = 1'b1;
        repeat (2) @(negedge CLK);
        chk("glitch.busy_pulse", bus.BUSY, 1'b1);
        idle(16);
        check_all("glitch_after", 1'b0);

        bad(8'h3C, 1'b0);
        repeat (40) @(negedge CLK);
        check_all("ferr_break", 1'b1);
        idle(5);
        check_all("ferr_released", 1'b0);

        a = pick_new(m_data);
        good(a, 1'b0);
        b = pick_new(a);
        good(b, 1'b1);
        check_all("load_ack_valid", 1'b0);
        ack_pulse();

        good(8'h11, 1'b0);
        good(8'h22, 1'b0);
        check_all("overrun", 1'b0);
        ack_pulse();
        check_all("overrun_ack", 1'b0);

        good(8'h55, 1'b0);
        ack_pulse();
        good(8'h66, 1'b1);
        check_all("load_ack", 1'b0);
        ack_pulse();

        a = pick_new(m_data);
        good(a, 1'b0);
        bad(pick_new(a), 1'b1);
        check_all("ferr_set_wins", 1'b1);
        idle(5);
        ack_pulse();

        frame(8'hFF, 1'b1, -1, 88, 89, 89);
        model_reset();
        check_all("reset_midframe", 1'b0);
        idle(10);
        good(8'h81, 1'b0);
        check_all("after_reset", 1'b0);
        ack_pulse();

        a = pick_new(m_data);
        model_reset();
        exp_q.push_back(a);
        frame(a, 1'b1, -1, 0, 2, 160);
        m_valid = 1'b1;
        m_data  = a;
        check_all("low_after_reset", 1'b0);
        ack_pulse();

        for (int i = 0; i < 8; i++) begin
            a = pick_new(m_data);
            good(a, m_valid ? 1'($urandom_range(0, 1)) : 1'b0);
            check_all("random", 1'b0);
            if ($urandom_range(0, 1) == 1) ack_pulse();
            idle(int'($urandom_range(0, 5)));
        end

        idle(4);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high, with ports named CLK and RST.
REQ-002 Parameter CLK_FREQ, default 50000000, SHALL be the CLK frequency in Hz.
REQ-003 Parameter BAUD, default 9600, SHALL be the line bit rate.
REQ-004 Derived constants: CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 4) and HALF = CLKS_PER_BIT/2.
REQ-005 CLK      input   1  50 MHz system clock.
REQ-006 RST      input   1  synchronous active-high reset.
REQ-007 RXD      input   1  asynchronous serial line; idles high.
REQ-008 ACK      input   1  consumer acknowledges DATA; one-cycle pulse or level.
REQ-009 DATA     output  8  last received byte.
REQ-010 VALID    output  1  DATA holds an unacknowledged byte.
REQ-011 BUSY     output  1  frame reception in progress (state != IDLE).
REQ-012 FERR     output  1  sticky framing error.
REQ-013 OVR      output  1  sticky overrun.

Function
REQ-014 RXD SHALL pass through a 2-flop synchronizer, with both flops resetting to 1; all logic below uses the synchronized value (rxs).
REQ-015 Frame format: 8N1, i.e. start bit 0, then 8 data bits LSB first, then stop bit 1.
REQ-016 The FSM states SHALL be IDLE, START, DATA, STOP, BREAK, and a bit-timer counts 0..CLKS_PER_BIT-1.
REQ-017 IDLE: rxs==0 -> START, timer=0, bit index=0.
REQ-018 START: at timer==HALF-1, rxs==0 -> DATA with timer=0; rxs==1 -> IDLE (glitch rejected, no flags changed).
REQ-019 DATA: at timer==CLKS_PER_BIT-1, shift rxs into the shift register (LSB first) and wrap the timer to 0; after the 8th bit -> STOP.
REQ-020 STOP: at timer==CLKS_PER_BIT-1, rxs==1 -> load DATA from the shift register, set VALID=1, and go to IDLE.
REQ-021 STOP: at timer==CLKS_PER_BIT-1, rxs==0 -> set FERR=1, leave DATA/VALID unchanged, discard the byte, and go to BREAK.
REQ-022 BREAK: remain until rxs==1, then -> IDLE; this prevents a held-low line from being decoded as repeated 0x00.
REQ-023 VALID SHALL rise on the clock edge that ends the stop-bit sample cycle, with no further latency.
REQ-024 ACK with VALID==1 SHALL clear VALID, FERR and OVR on the next edge.
REQ-025 ACK with VALID==0 SHALL clear FERR and OVR only.
REQ-026 Load with VALID==1 and no ACK in the same cycle -> DATA is overwritten, VALID stays 1, and OVR is set.
REQ-027 Load and ACK in the same cycle -> load wins: DATA is new, VALID stays 1, OVR is not set, and FERR is cleared.
REQ-028 FERR set and ACK in the same cycle -> FERR=1 (set wins).
REQ-029 BUSY SHALL be 1 in START, DATA, STOP and BREAK.
REQ-030 There SHALL be no sampling-point resynchronization within a frame; the accumulated error budget is the caller's concern.

Reset
REQ-031 RST SHALL force the following on the next edge: state=IDLE, timer=0, bit index=0, shift register=0, DATA=0x00, VALID=0, BUSY=0, FERR=0, OVR=0, synchronizer flops=1.
REQ-032 RST asserted mid-frame SHALL abandon the frame without setting any flag.
REQ-033 After RST, a line already low SHALL be treated as a start bit.

Verification (CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16)
REQ-034 Bench case 1, single byte: send 0xA5 as 8N1 at 16 clks/bit -> DATA=0xA5 and VALID=1; then ACK -> VALID=0.
REQ-035 Bench case 2, glitch: RXD low for 4 clks then high -> BUSY pulses, state returns to IDLE, VALID=0 and FERR=0.
REQ-036 Bench case 3, framing error: send 0x3C with stop bit 0, then hold RXD low for 40 clks -> FERR=1, VALID=0, BUSY=1 until RXD returns high, and no 0x00 byte is received.
REQ-037 Bench case 4, overrun: send 0x11 then 0x22 with no ACK -> DATA=0x22, VALID=1, OVR=1; then ACK -> OVR=0 and VALID=0.
REQ-038 Bench case 5, same-cycle load and ACK: send 0x55, ACK, then send 0x66 with ACK pulsed on the load cycle -> DATA=0x66, VALID=1, OVR=0.
REQ-039 Bench case 6, reset mid-frame: assert RST during data bit 4 of 0xFF -> next cycle BUSY=0, DATA=0x00, VALID=0; a following 0x81 is received correctly.
